// File: rtl/image_line_writer.sv
// image_line_writer: packs 24-bit background/mask pixel pairs into three
// interleaved {mask byte, bg byte} words and writes them to SDRAM one at a
// time over a req/ack port, tracking x/y position and frame completion.
//
// Handshakes: pixel input is valid/ready (a pixel is consumed on a cycle
// where pixel_valid && pixel_ready); the SDRAM port is a one-cycle
// sd_wr_req pulse with sd_addr/sd_data held until the one-cycle sd_wr_ack.
module image_line_writer #(
    parameter int          WIDTH     = 720,
    parameter int          HEIGHT    = 720,
    parameter logic [24:0] BASE_ADDR = 25'h0
) (
    input  logic        clk_sys_131_072,
    input  logic        reset,
    input  logic        start,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    input  logic [23:0] pixel_bg,
    input  logic [23:0] pixel_mask,
    output logic        sd_wr_req,
    output logic [24:0] sd_addr,
    output logic [15:0] sd_data,
    input  logic        sd_wr_ack,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        busy,
    output logic        frame_done,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
    localparam logic [9:0] Y_LAST = 10'(HEIGHT - 1);

    state_t      state_q, state_d;
    logic [24:0] addr_cnt_q, addr_cnt_d;
    logic [23:0] bg_q, bg_d;
    logic [23:0] mask_q, mask_d;
    logic [1:0]  k_q, k_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        sd_wr_req_q, sd_wr_req_d;
    logic [24:0] sd_addr_q, sd_addr_d;
    logic [15:0] sd_data_q, sd_data_d;

    // Byte lane k of the pixel pair: {mask byte k, bg byte k}.
    function automatic logic [15:0] pack_word(input logic [1:0]  k,
                                              input logic [23:0] bg,
                                              input logic [23:0] mask);
        logic [15:0] w;
        case (k)
            2'd0:    w = {mask[7:0],   bg[7:0]};
            2'd1:    w = {mask[15:8],  bg[15:8]};
            default: w = {mask[23:16], bg[23:16]};
        endcase
        return w;
    endfunction

    // Next-state and next-output logic for the write sequencer.
    always_comb begin
        state_d      = state_q;
        addr_cnt_d   = addr_cnt_q;
        bg_d         = bg_q;
        mask_d       = mask_q;
        k_d          = k_q;
        x_d          = x_q;
        y_d          = y_q;
        busy_d       = busy_q;
        frame_done_d = frame_done_q;
        sd_wr_req_d  = 1'b0;
        sd_addr_d    = sd_addr_q;
        sd_data_d    = sd_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_ACCEPT;
                    addr_cnt_d   = BASE_ADDR;
                    x_d          = '0;
                    y_d          = '0;
                    busy_d       = 1'b1;
                    frame_done_d = 1'b0;
                end
            end
            S_ACCEPT: begin
                // start beats a coincident pixel: the pixel is dropped.
                if (start) begin
                    addr_cnt_d = BASE_ADDR;
                    x_d        = '0;
                    y_d        = '0;
                end else if (pixel_valid) begin
                    bg_d        = pixel_bg;
                    mask_d      = pixel_mask;
                    k_d         = 2'd0;
                    state_d     = S_ISSUE;
                    sd_wr_req_d = 1'b1;
                    sd_addr_d   = addr_cnt_q;
                    sd_data_d   = pack_word(2'd0, pixel_bg, pixel_mask);
                end
            end
            S_ISSUE: begin
                state_d = start ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (sd_wr_ack && start) begin
                    // Outstanding write already finished: restart directly.
                    state_d    = S_ACCEPT;
                    addr_cnt_d = BASE_ADDR;
                    x_d        = '0;
                    y_d        = '0;
                end else if (sd_wr_ack) begin
                    addr_cnt_d = addr_cnt_q + 25'd1;
                    if (k_q != 2'd2) begin
                        k_d         = k_q + 2'd1;
                        state_d     = S_ISSUE;
                        sd_wr_req_d = 1'b1;
                        sd_addr_d   = addr_cnt_q + 25'd1;
                        sd_data_d   = pack_word(k_q + 2'd1, bg_q, mask_q);
                    end else if (x_q == X_LAST && y_q == Y_LAST) begin
                        // Last pixel of the frame: position returns to origin.
                        x_d          = '0;
                        y_d          = '0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else if (x_q == X_LAST) begin
                        x_d     = '0;
                        y_d     = y_q + 10'd1;
                        state_d = S_ACCEPT;
                    end else begin
                        x_d     = x_q + 10'd1;
                        state_d = S_ACCEPT;
                    end
                end else if (start) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Let the in-flight write complete before restarting.
                if (sd_wr_ack) begin
                    state_d    = S_ACCEPT;
                    addr_cnt_d = BASE_ADDR;
                    x_d        = '0;
                    y_d        = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys_131_072) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_cnt_q   <= '0;
            bg_q         <= '0;
            mask_q       <= '0;
            k_q          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            sd_wr_req_q  <= 1'b0;
            sd_addr_q    <= '0;
            sd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_cnt_q   <= addr_cnt_d;
            bg_q         <= bg_d;
            mask_q       <= mask_d;
            k_q          <= k_d;
            x_q          <= x_d;
            y_q          <= y_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            sd_wr_req_q  <= sd_wr_req_d;
            sd_addr_q    <= sd_addr_d;
            sd_data_q    <= sd_data_d;
        end
    end

    assign pixel_ready = (state_q == S_ACCEPT);
    assign sd_wr_req   = sd_wr_req_q;
    assign sd_addr     = sd_addr_q;
    assign sd_data     = sd_data_q;
    assign x           = x_q;
    assign y           = y_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_image_line_writer.sv
// Testbench for image_line_writer on a 4x2 frame. A reference model tracks
// the pixel index within the frame and derives every expected write as
// BASE + n*3 + k with data {mask byte k, bg byte k}, plus the x/y position.
module tb_image_line_writer;
  localparam int W = 4;
  localparam int H = 2;
  localparam logic [24:0] BASE = 25'h0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic [23:0] pixel_bg = '0;
  logic [23:0] pixel_mask = '0;
  logic        sd_wr_req;
  logic [24:0] sd_addr;
  logic [15:0] sd_data;
  logic        sd_wr_ack = 1'b0;
  logic [9:0]  x, y;
  logic        busy, frame_done;
  logic [2:0]  state_dbg;

  image_line_writer #(.WIDTH(W), .HEIGHT(H), .BASE_ADDR(BASE)) dut (
    .clk_sys_131_072(clk),
    .reset(reset),
    .start(start),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .pixel_bg(pixel_bg),
    .pixel_mask(pixel_mask),
    .sd_wr_req(sd_wr_req),
    .sd_addr(sd_addr),
    .sd_data(sd_data),
    .sd_wr_ack(sd_wr_ack),
    .x(x),
    .y(y),
    .busy(busy),
    .frame_done(frame_done),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int errors = 0;
  int checks = 0;
  int n_pix = 0;               // pixels accepted in the current frame
  logic [40:0] exp_q[$];       // {addr[24:0], data[15:0]}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_new_frame();
    n_pix = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    model_new_frame();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(pixel_ready), 64'd0);
    check({tag, "_req"},   64'(sd_wr_req),   64'd0);
    check({tag, "_addr"},  64'(sd_addr),     64'd0);
    check({tag, "_data"},  64'(sd_data),     64'd0);
    check({tag, "_x"},     64'(x),           64'd0);
    check({tag, "_y"},     64'(y),           64'd0);
    check({tag, "_busy"},  64'(busy),        64'd0);
    check({tag, "_done"},  64'(frame_done),  64'd0);
  endtask

  task automatic accept_pixel(input logic [23:0] bg, input logic [23:0] mask);
    int t;
    pixel_bg = bg;
    pixel_mask = mask;
    pixel_valid = 1'b1;
    t = 0;
    while (!pixel_ready && t < 50) begin
      step();
      t++;
    end
    check("accept_ready", 64'(pixel_ready), 64'd1);
    step();
    pixel_valid = 1'b0;
    for (int k = 0; k < 3; k++)
      exp_q.push_back({25'(int'(BASE) + n_pix * 3 + k), mask[8*k +: 8], bg[8*k +: 8]});
    n_pix++;
  endtask

  // Waits (bounded) for a request and checks it against the next expected word.
  task automatic take_req();
    int t;
    logic [40:0] e;
    t = 0;
    while (!sd_wr_req && t < 30) begin
      step();
      t++;
    end
    check("req_seen", 64'(sd_wr_req), 64'd1);
    if (exp_q.size() == 0) begin
      check("exp_q_nonempty", 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check("wr_addr", 64'(sd_addr), 64'(e[40:16]));
      check("wr_data", 64'(sd_data), 64'(e[15:0]));
    end
  endtask

  // Acks the outstanding write d (>=1) cycles into WAIT; req must stay low.
  task automatic ack_after(input int d);
    logic [24:0] a;
    logic [15:0] dt;
    a = sd_addr;
    dt = sd_data;
    step();
    check("req_one_cycle", 64'(sd_wr_req), 64'd0);
    repeat (d - 1) step();
    check("addr_held", 64'(sd_addr), 64'(a));
    check("data_held", 64'(sd_data), 64'(dt));
    sd_wr_ack = 1'b1;
    step();
    sd_wr_ack = 1'b0;
  endtask

  task automatic send_pixel(input logic [23:0] bg, input logic [23:0] mask,
                            input int lo, input int hi);
    accept_pixel(bg, mask);
    for (int k = 0; k < 3; k++) begin
      take_req();
      ack_after(int'($urandom_range(hi, lo)));
    end
    if (n_pix < W * H) begin
      check("pos_x", 64'(x), 64'(n_pix % W));
      check("pos_y", 64'(y), 64'(n_pix / W));
      check("ready_after_pixel", 64'(pixel_ready), 64'd1);
    end else begin
      check("frame_done", 64'(frame_done), 64'd1);
      check("busy_end", 64'(busy), 64'd0);
      check("ready_end", 64'(pixel_ready), 64'd0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int bad;
    logic [24:0] a0;

    // Reset, then idle with pixel_valid held high and no start.
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    pixel_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pixel_ready || sd_wr_req) bad++;
    end
    check("idle_no_ready_or_req", 64'(bad), 64'd0);
    check_all_zero("reset");
    pixel_valid = 1'b0;

    // Single known pixel, ack 2 cycles after each request.
    pulse_start();
    check("start_busy", 64'(busy), 64'd1);
    check("start_ready", 64'(pixel_ready), 64'd1);
    send_pixel(24'h332211, 24'hCCBBAA, 2, 2);
    check("known_x", 64'(x), 64'd1);

    // Spurious ack in ACCEPT: nothing moves; next pixel continues at addr 3.
    a0 = sd_addr;
    sd_wr_ack = 1'b1;
    step();
    sd_wr_ack = 1'b0;
    step();
    check("spur_ready", 64'(pixel_ready), 64'd1);
    check("spur_req", 64'(sd_wr_req), 64'd0);
    check("spur_x", 64'(x), 64'd1);
    check("spur_y", 64'(y), 64'd0);
    check("spur_addr", 64'(sd_addr), 64'(a0));
    send_pixel(24'($urandom), 24'($urandom), 1, 3);

    // Full 4x2 frame with random pixels and random ack delays.
    pulse_start();
    for (int p = 0; p < W * H; p++)
      send_pixel(24'($urandom), 24'($urandom), 1, 10);
    check("frame_q_empty", 64'(exp_q.size()), 64'd0);

    // frame_done holds; pixel_valid without start is ignored.
    pixel_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sd_wr_req || pixel_ready || !frame_done) bad++;
    end
    pixel_valid = 1'b0;
    check("done_hold_idle", 64'(bad), 64'd0);

    // Mid-frame start during WAIT with a late ack.
    pulse_start();
    check("done_cleared", 64'(frame_done), 64'd0);
    send_pixel(24'($urandom), 24'($urandom), 1, 4);
    accept_pixel(24'($urandom), 24'($urandom));
    take_req();
    step();                    // now in WAIT
    start = 1'b1;
    step();
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (sd_wr_req || pixel_ready) bad++;
      step();
    end
    check("drain_no_req", 64'(bad), 64'd0);
    sd_wr_ack = 1'b1;
    step();
    sd_wr_ack = 1'b0;
    model_new_frame();
    check("drain_ready", 64'(pixel_ready), 64'd1);
    check("drain_x", 64'(x), 64'd0);
    check("drain_y", 64'(y), 64'd0);
    check("drain_busy", 64'(busy), 64'd1);
    send_pixel(24'($urandom), 24'($urandom), 1, 5);

    // start coincident with a pixel handshake: pixel dropped, restart.
    pixel_bg = 24'($urandom);
    pixel_mask = 24'($urandom);
    pixel_valid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    pixel_valid = 1'b0;
    model_new_frame();
    check("startwin_req", 64'(sd_wr_req), 64'd0);
    check("startwin_ready", 64'(pixel_ready), 64'd1);
    check("startwin_x", 64'(x), 64'd0);
    send_pixel(24'($urandom), 24'($urandom), 1, 5);

    // Reset during WAIT, then a late ack: block stays idle.
    accept_pixel(24'($urandom), 24'($urandom));
    take_req();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_new_frame();
    repeat (3) step();
    sd_wr_ack = 1'b1;
    step();
    sd_wr_ack = 1'b0;
    step();
    step();
    check_all_zero("rst_wait");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
